timer_dev: RTL and testbench

TIMER_DEV -- requirements
Module: timer_dev

---
 rtl/timer_pkg.sv | 35 +++
 rtl/timer_dev_if.sv | 26 ++
 rtl/timer_dev.sv | 143 ++++++++++++++
 tb/tb_timer_dev.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg -- shared definitions for the timer_dev register block.
//   * FSM state encoding (also driven on the debug state output)
//   * register word offsets (bus byte-address bits [3:2])
//   * CTRL bit indices and Mode encodings
// No ports; imported by timer_dev_if and timer_dev.
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Register word offsets
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_PRESET = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // Mode encodings; 2 and 3 behave as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_dev_if.sv
// -----------------------------------------------------------------------------
// timer_dev_if -- CPU register bus for timer_dev.
//   addr  [1:0]  word select (CTRL/PRESET/COUNT/unused)
//   we           write strobe, sampled on the rising clock edge
//   wdata [31:0] write data
//   rdata [31:0] combinational read data for addr
//   irq          interrupt request to the CPU
// Modports: master (CPU side), slave (timer side).
//
// Handshake: there is no valid/ready pair. The slave is always ready: a write
// is accepted on every rising edge where we=1, and rdata is valid in the same
// cycle addr is presented, with no wait states.
// -----------------------------------------------------------------------------
interface timer_dev_if;
  import timer_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              irq;

  modport master (output addr, output we, output wdata, input rdata, input irq);
  modport slave  (input addr, input we, input wdata, output rdata, output irq);

endinterface

// File: rtl/timer_dev.sv
// -----------------------------------------------------------------------------
// timer_dev -- memory-mapped down-counting timer with interrupt.
// Registers: CTRL (Enable, Mode, IM), PRESET (reload value), COUNT (read-only).
// FSM IDLE -> LOAD -> CNT -> INT; one-shot returns to IDLE and clears Enable,
// auto-reload returns to LOAD (period PRESET+2 cycles).
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   bus          timer_dev_if.slave (addr, we, wdata, rdata, irq)
//   dbg_state_o  current FSM state for observation
//
// Build option: define TIMER_IRQ_EN to make IM writable and drive
// irq = IM & pending. Without it, IM reads 0 and irq is tied low, while the
// internal pending flag keeps its normal behaviour.
// -----------------------------------------------------------------------------
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  timer_dev_if.slave        bus,
  output state_e            dbg_state_o
);

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        im_val;
  logic        ctrl_wr, preset_wr;
  logic [31:0] rdata_w;

  assign ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
  assign preset_wr = bus.we && (bus.addr == ADDR_PRESET);

`ifdef TIMER_IRQ_EN
  logic im_q, im_d;

  always_comb begin
    im_d = im_q;
    if (ctrl_wr) im_d = bus.wdata[CTRL_IM_BIT];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) im_q <= 1'b0;
    else       im_q <= im_d;
  end

  assign im_val  = im_q;
  assign bus.irq = im_q & pending_q;
`else
  assign im_val  = 1'b0;
  assign bus.irq = 1'b0;
`endif

  // Next-state logic. The FSM acts on pre-edge register values; a CTRL write
  // is applied last so it overrides the FSM's Enable clear and pending set.
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    mode_d    = mode_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;

    case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // COUNT of 1 or 0: land on zero and raise pending
          count_d   = 32'd0;
          pending_d = 1'b1;
          state_d   = ST_INT;
        end
      end
      ST_INT: begin
        if (mode_q == MODE_RELOAD) begin
          pending_d = 1'b0;
          state_d   = ST_LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (preset_wr) preset_d = bus.wdata;

    if (ctrl_wr) begin
      en_d      = bus.wdata[CTRL_EN_BIT];
      mode_d    = bus.wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      en_q      <= 1'b0;
      mode_q    <= MODE_ONESHOT;
      preset_q  <= PRESET_RST;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    rdata_w = 32'd0;
    case (bus.addr)
      ADDR_CTRL:   rdata_w = {28'd0, im_val, mode_q, en_q};
      ADDR_PRESET: rdata_w = preset_q;
      ADDR_COUNT:  rdata_w = count_q;
      default:     rdata_w = 32'd0;
    endcase
  end

  assign bus.rdata   = rdata_w;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_timer_dev.sv
// -----------------------------------------------------------------------------
// tb_timer_dev -- directed bench for timer_dev.
// Driver tasks change bus inputs 1 time unit after each rising edge and push
// the expected {check_state, state, irq, rdata} for that cycle; a monitor pops
// and compares on the following falling edge.
// "After edge k" below counts edge 0 as the edge that accepts the CTRL write.
// -----------------------------------------------------------------------------
module tb_timer_dev;
  import timer_pkg::*;

  localparam logic [31:0] PR = 32'h0000_00A5;
`ifdef TIMER_IRQ_EN
  localparam bit IE = 1'b1;
`else
  localparam bit IE = 1'b0;
`endif
  // CTRL readback values depend on whether IM is implemented
  localparam logic [31:0] CTRL_9 = IE ? 32'h9 : 32'h1;
  localparam logic [31:0] CTRL_B = IE ? 32'hB : 32'h3;
  localparam logic [31:0] CTRL_8 = IE ? 32'h8 : 32'h0;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   reset;
  state_e dbg_state;

  always #5 clk = ~clk;

  timer_dev_if bus ();

  timer_dev #(.PRESET_RST(PR)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [35:0] e;
  string       nm;
  bit          ok;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      ok = (bus.rdata === e[31:0]) && (bus.irq === e[32]);
      if (e[35] && (dbg_state !== state_e'(e[34:33]))) ok = 1'b0;
      if (!ok) begin
        n_bad++;
        $display("FAIL %s: got rdata=%h irq=%b state=%0d, expected rdata=%h irq=%b state=%0d%s",
                 nm, bus.rdata, bus.irq, dbg_state, e[31:0], e[32], e[34:33],
                 e[35] ? "" : " (state not checked)");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] a, input logic w, input logic [31:0] wd,
                       input bit chk, input logic [31:0] er, input logic ei,
                       input bit cs, input state_e es, input string n);
    bus.addr  = a;
    bus.we    = w;
    bus.wdata = wd;
    if (chk) begin
      exp_q.push_back({cs, es, ei, er});
      name_q.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    drive(a, 1'b1, wd, 1'b0, 32'd0, 1'b0, 1'b0, ST_IDLE, "");
  endtask

  task automatic wr_chk(input logic [1:0] a, input logic [31:0] wd, input logic [31:0] er,
                        input logic ei, input state_e es, input string n);
    drive(a, 1'b1, wd, 1'b1, er, ei, 1'b1, es, n);
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] er, input logic ei, input string n);
    drive(a, 1'b0, 32'd0, 1'b1, er, ei, 1'b0, ST_IDLE, n);
  endtask

  task automatic rd_st(input logic [1:0] a, input logic [31:0] er, input logic ei,
                       input state_e es, input string n);
    drive(a, 1'b0, 32'd0, 1'b1, er, ei, 1'b1, es, n);
  endtask

  task automatic idle();
    drive(ADDR_CTRL, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, ST_IDLE, "");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.addr  = '0;
    bus.we    = 1'b0;
    bus.wdata = '0;
    reset     = 1'b1;
    @(posedge clk);
    #1;

    // Reset values
    rd(ADDR_CTRL, 32'd0, 1'b0, "rst_ctrl");
    rd(ADDR_PRESET, PR, 1'b0, "rst_preset");
    rd_st(ADDR_COUNT, 32'd0, 1'b0, ST_IDLE, "rst_count");
    reset = 1'b0;

    // Register map: reserved CTRL bits, read-only COUNT, unused addr 3
    wr(ADDR_CTRL, 32'hFFFF_FFF0);
    rd(ADDR_CTRL, 32'd0, 1'b0, "ctrl_rsvd_bits");
    wr(ADDR_PRESET, 32'hDEAD_BEEF);
    rd(ADDR_PRESET, 32'hDEAD_BEEF, 1'b0, "preset_rw");
    wr(ADDR_COUNT, 32'h0000_1234);
    rd(ADDR_COUNT, 32'd0, 1'b0, "count_ro");
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, 32'd0, 1'b0, "addr3_zero");
    wr(ADDR_CTRL, 32'h6);
    rd_st(ADDR_CTRL, 32'h6, 1'b0, ST_IDLE, "ctrl_mode3_noen");

    // One-shot: PRESET=3, CTRL=0x9
    wr(ADDR_PRESET, 32'd3);
    wr(ADDR_CTRL, 32'h9);
    rd_st(ADDR_COUNT, 32'd0, 1'b0, ST_IDLE, "os_e0");
    rd_st(ADDR_CTRL, CTRL_9, 1'b0, ST_LOAD, "os_e1_ctrl");
    rd_st(ADDR_COUNT, 32'd3, 1'b0, ST_CNT, "os_e2");
    rd(ADDR_COUNT, 32'd2, 1'b0, "os_e3");
    rd(ADDR_COUNT, 32'd1, 1'b0, "os_e4");
    rd_st(ADDR_COUNT, 32'd0, IE, ST_INT, "os_e5_irq");
    rd_st(ADDR_CTRL, CTRL_8, IE, ST_IDLE, "os_e6_ctrl");
    rd(ADDR_COUNT, 32'd0, IE, "os_e7_irq_held");
    wr(ADDR_CTRL, 32'h8);
    rd(ADDR_CTRL, CTRL_8, 1'b0, "os_ctrl_wr_clears");

    // Auto-reload: PRESET=2, CTRL=0xB -> COUNT 2,1,0,0 every 4 cycles
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'hB);
    rd(ADDR_CTRL, CTRL_B, 1'b0, "ar_ctrl");
    rd_st(ADDR_COUNT, 32'd0, 1'b0, ST_LOAD, "ar_load");
    for (int k = 0; k < 9; k++) begin
      logic [31:0] c;
      case (k % 4)
        0:       c = 32'd2;
        1:       c = 32'd1;
        default: c = 32'd0;
      endcase
      rd(ADDR_COUNT, c, IE && ((k % 4) == 2), $sformatf("ar_cycle%0d", k));
    end
    wr(ADDR_CTRL, 32'h8);

    // Disable mid-count: write lands on the edge where COUNT becomes 5
    wr(ADDR_PRESET, 32'd7);
    wr(ADDR_CTRL, 32'h9);
    idle();
    idle();
    rd(ADDR_COUNT, 32'd7, 1'b0, "dis_e2");
    wr(ADDR_CTRL, 32'h0);
    rd_st(ADDR_COUNT, 32'd5, 1'b0, ST_CNT, "dis_e4");
    rd_st(ADDR_COUNT, 32'd5, 1'b0, ST_IDLE, "dis_e5_idle");
    rd(ADDR_CTRL, 32'd0, 1'b0, "dis_ctrl");
    rd(ADDR_COUNT, 32'd5, 1'b0, "dis_hold");

    // Collision: CTRL write on the pending-set edge, then on the INT->IDLE edge
    wr(ADDR_PRESET, 32'd2);
    wr(ADDR_CTRL, 32'h9);
    idle();
    idle();
    rd(ADDR_COUNT, 32'd2, 1'b0, "col_e2");
    wr_chk(ADDR_CTRL, 32'h9, CTRL_9, 1'b0, ST_CNT, "col_e3");
    wr_chk(ADDR_CTRL, 32'h9, CTRL_9, 1'b0, ST_INT, "col_e4_no_pending");
    rd_st(ADDR_CTRL, CTRL_9, 1'b0, ST_IDLE, "col_e5_en_kept");
    rd_st(ADDR_COUNT, 32'd0, 1'b0, ST_LOAD, "col_e6_reload");
    rd(ADDR_COUNT, 32'd2, 1'b0, "col_e7");
    wr(ADDR_CTRL, 32'h8);

    // PRESET write during CNT does not disturb COUNT
    wr(ADDR_PRESET, 32'd6);
    wr(ADDR_CTRL, 32'h9);
    idle();
    idle();
    rd(ADDR_COUNT, 32'd6, 1'b0, "pw_e2");
    rd(ADDR_COUNT, 32'd5, 1'b0, "pw_e3");
    wr_chk(ADDR_PRESET, 32'h50, 32'd6, 1'b0, ST_CNT, "pw_e4_old_preset");
    rd(ADDR_COUNT, 32'd3, 1'b0, "pw_e5");
    rd(ADDR_COUNT, 32'd2, 1'b0, "pw_e6");
    rd(ADDR_COUNT, 32'd1, 1'b0, "pw_e7");
    rd_st(ADDR_COUNT, 32'd0, IE, ST_INT, "pw_e8_irq");
    rd_st(ADDR_CTRL, CTRL_8, IE, ST_IDLE, "pw_e9_ctrl");
    rd(ADDR_PRESET, 32'h50, IE, "pw_new_preset");
    wr(ADDR_CTRL, 32'h8);

    // Reset mid-count: immediate clear, and no irq afterwards
    wr(ADDR_PRESET, 32'd10);
    wr(ADDR_CTRL, 32'h9);
    idle();
    idle();
    idle();
    rd(ADDR_COUNT, 32'd9, 1'b0, "rm_e3");
    reset = 1'b1;
    rd_st(ADDR_COUNT, 32'd0, 1'b0, ST_IDLE, "rm_count");
    rd(ADDR_CTRL, 32'd0, 1'b0, "rm_ctrl");
    rd(ADDR_PRESET, PR, 1'b0, "rm_preset");
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      rd_st(ADDR_COUNT, 32'd0, 1'b0, ST_IDLE, $sformatf("rm_after%0d", k));
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
